bus_primary_lsu: RTL and testbench
==================================

// Module: bus_primary_lsu
// PURPOSE
//  Load/store initiator that drives otter_bus as primary on behalf of the CPU datapath.
//  Accepts one request at a time and issues a single-cycle rd/wr strobe with a stable address.
//  Waits a fixed response latency, then returns the result on a one-cycle response pulse:
//  lane-extracted, sign/zero-extended load data, plus the secondary's error flag.
//  Sits between the multicycle control unit and the memory-side secondaries (sram, MMIO).
// PARAMETERS
//  ADDR_WIDTH  32  width of req_addr / bus.addr
//  BUS_WIDTH   32  data width (fixed 4 byte lanes)
//  LATENCY     1   cycles from the rd/wr strobe cycle to the rdata/error sample cycle (>=1)
// PORTS
//  clk          in   1           system clock, rising edge
//  rst          in   1           asynchronous, active-high reset
//  req_valid    in   1           request present
//  req_ready    out  1           unit idle; request accepted when req_valid && req_ready
//  req_we       in   1           1 = store, 0 = load
//  req_size     in   2           00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned in   1           load zero-extends when 1, sign-extends when 0
//  req_addr     in   ADDR_WIDTH  byte address
//  req_wdata    in   BUS_WIDTH   store data, right-justified
//  resp_valid   out  1           one-cycle response pulse
//  resp_rdata   out  BUS_WIDTH   extended load data (0 for stores and errors)
//  resp_error   out  1           access fault (bus.error, or illegal size)
//  bus          --   if          otter_bus.primary: addr,size,wdata,rd,wr out; rdata,error in
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; bus.rd=bus.wr=0; bus.addr/size/wdata=0;
//   resp_valid=0, resp_rdata=0, resp_error=0; counter=0. req_ready=1 after reset release.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; all outputs driven from registers.
//  IDLE: req_ready=1; on accept, register addr/size/we/unsigned; go ISSUE (or RESP if size==11).
//   Store data is lane-replicated at capture: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
//  ISSUE: exactly one cycle; bus.rd=!we, bus.wr=we; counter loaded with LATENCY-1; go WAIT.
//  WAIT: rd=wr=0; addr/size/wdata held; when counter==0, sample bus.rdata and bus.error; go RESP; else decrement.
//  RESP: resp_valid=1 for exactly one cycle; go IDLE. req_ready=0 in ISSUE/WAIT/RESP.
//  Timing (LATENCY=1): accept edge closes cycle 0; ISSUE in cycle 1; sample in cycle 2;
//   resp_valid high in cycle 3. In general, resp_valid is high in cycle 2+LATENCY.
//  Load extraction: byte lane=addr[1:0], half lane=addr[1]; extend to 32 bits per req_unsigned.
//  Error: resp_error=bus.error sampled; on error resp_rdata=0. Alignment is not checked here;
//   the secondary flags it. size==11: no bus strobe; RESP the cycle after accept, resp_error=1.
//  Stores: resp_rdata=0; resp_error still reported.
//  bus.addr/size/wdata keep their last values in IDLE; only rd/wr return to 0.
//  Reset mid-transaction: strobe dropped immediately; no response is ever issued for that request.
//  A request held across RESP is accepted only after the return to IDLE; no back-to-back accept.
// TESTING
//  1 Store word 0xDEADBEEF @0x100 -> wr=1 for one cycle, size=10, wdata=0xDEADBEEF; resp_valid in cycle 3, error=0.
//  2 Store byte 0xA5 @0x103, then load byte signed @0x103 -> wdata=0xA5A5A5A5; resp_rdata=0xFFFFFFA5; unsigned gives 0x000000A5.
//  3 Load half @0x102 with word 0x8001_1234 stored -> signed 0xFFFF8001; unsigned 0x00008001.
//  4 Load word @0x101 (secondary raises error) -> resp_error=1, resp_rdata=0; size=11 -> no rd/wr strobe, error in cycle 1.
//  5 LATENCY=3 build: load -> resp_valid in cycle 5; req_valid held high throughout -> req_ready low until IDLE, single accept per request.
//  6 Assert rst during WAIT -> rd/wr/resp_valid go to 0 immediately; no resp_valid after release; next request completes normally.

Source files
------------

// File: rtl/bus_primary_lsu_if.sv
// otter_bus: shared address/data bus between one primary and its secondaries.
// Latency: n/a (wires only); secondaries return rdata/error a fixed number of cycles after the strobe.
// Backpressure: none on the bus itself; the primary holds addr/size/wdata until it samples the reply.
//
// Signals:
//   addr   primary -> secondary  byte address, held from the strobe cycle to the sample cycle
//   size   primary -> secondary  00 byte, 01 half, 10 word
//   wdata  primary -> secondary  store data, already replicated across the byte lanes
//   rd/wr  primary -> secondary  single-cycle access strobes
//   rdata  secondary -> primary  aligned 32-bit word containing the addressed lanes
//   error  secondary -> primary  access fault (misalignment, unmapped address, ...)
interface otter_bus #(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            size;
  logic [BUS_WIDTH-1:0]  wdata;
  logic                  rd;
  logic                  wr;
  logic [BUS_WIDTH-1:0]  rdata;
  logic                  error;

  modport primary (
    output addr, size, wdata, rd, wr,
    input  rdata, error
  );

  modport secondary (
    input  addr, size, wdata, rd, wr,
    output rdata, error
  );
endinterface

// File: rtl/bus_primary_lsu.sv
// Load/store initiator driving otter_bus as primary for the CPU datapath, one request at a time.
// Latency: response pulse 2+LATENCY cycles after the accept edge; illegal size responds the next cycle.
// Backpressure: req_ready is high only in IDLE; a request held across RESP is taken after the return to IDLE.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   req_valid/ready  request handshake; fields req_we, req_size, req_unsigned, req_addr, req_wdata
//   resp_valid       one-cycle response pulse carrying resp_rdata (extended load data) and resp_error
//   bus              otter_bus primary side: addr/size/wdata/rd/wr out, rdata/error in
module bus_primary_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BUS_WIDTH-1:0]  req_wdata,
  output logic                  resp_valid,
  output logic [BUS_WIDTH-1:0]  resp_rdata,
  output logic                  resp_error,
  otter_bus.primary             bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  // Request attributes needed after the bus strobe to shape the response.
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       uns;
    logic [1:0] lane;
  } req_t;

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t                state;
  req_t                  req_q;
  logic [CNT_W-1:0]      cnt;
  logic                  ready_q;
  logic                  rd_q;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic [BUS_WIDTH-1:0]  wdata_q;
  logic                  resp_valid_q;
  logic [BUS_WIDTH-1:0]  resp_rdata_q;
  logic                  resp_error_q;

  // Stores are presented on every lane so the secondary can pick its lane
  // from addr/size without a shifter of its own.
  function automatic logic [BUS_WIDTH-1:0] replicate(input logic [1:0] size,
                                                     input logic [BUS_WIDTH-1:0] d);
    logic [BUS_WIDTH-1:0] r;
    r = d;
    case (size)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Pick the addressed lane out of the aligned read word and extend it.
  function automatic logic [BUS_WIDTH-1:0] extract(input req_t r,
                                                   input logic [BUS_WIDTH-1:0] w);
    logic [7:0]           b;
    logic [15:0]          h;
    logic [BUS_WIDTH-1:0] res;
    b   = w[7:0];
    h   = w[15:0];
    res = w;
    case (r.lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = r.lane[1] ? w[31:16] : w[15:0];
    case (r.size)
      2'b00:   res = {{24{~r.uns & b[7]}}, b};
      2'b01:   res = {{16{~r.uns & h[15]}}, h};
      default: res = w;
    endcase
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      req_q        <= '0;
      cnt          <= '0;
      ready_q      <= 1'b1;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && ready_q) begin
            ready_q <= 1'b0;
            req_q   <= '{we: req_we, size: req_size, uns: req_unsigned, lane: req_addr[1:0]};
            if (req_size == 2'b11) begin
              // Illegal size never reaches the bus; fault straight away.
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              resp_rdata_q <= '0;
              state        <= S_RESP;
            end else begin
              addr_q  <= req_addr;
              size_q  <= req_size;
              wdata_q <= replicate(req_size, req_wdata);
              rd_q    <= ~req_we;
              wr_q    <= req_we;
              state   <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          rd_q  <= 1'b0;
          wr_q  <= 1'b0;
          cnt   <= CNT_LOAD;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // addr/size/wdata stay put so the secondary sees a stable access.
          if (cnt == '0) begin
            resp_valid_q <= 1'b1;
            resp_error_q <= bus.error;
            if (bus.error || req_q.we) begin
              resp_rdata_q <= '0;
            end else begin
              resp_rdata_q <= extract(req_q, bus.rdata);
            end
            state <= S_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          resp_valid_q <= 1'b0;
          ready_q      <= 1'b1;
          state        <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;
  assign bus.addr   = addr_q;
  assign bus.size   = size_q;
  assign bus.wdata  = wdata_q;
  assign bus.rd     = rd_q;
  assign bus.wr     = wr_q;

endmodule

// File: tb/tb_bus_primary_lsu.sv
module tb_bus_primary_lsu;
  localparam int MEM_BYTES = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mem_clr;
  logic        valid1, valid3, ready1, ready3;
  logic        req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rv1, rv3, re1, re3;
  logic [31:0] rd1, rd3;

  int total = 0;
  int bad   = 0;

  // Results of the most recent run_req, for directed checks.
  logic [31:0] last_rd1, last_swd1;
  logic        last_err1;
  int          last_rc1, last_sn1;

  otter_bus #(.ADDR_WIDTH(32), .BUS_WIDTH(32)) b1 ();
  otter_bus #(.ADDR_WIDTH(32), .BUS_WIDTH(32)) b3 ();

  bus_primary_lsu #(.ADDR_WIDTH(32), .BUS_WIDTH(32), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(valid1), .req_ready(ready1), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rv1), .resp_rdata(rd1), .resp_error(re1), .bus(b1)
  );

  bus_primary_lsu #(.ADDR_WIDTH(32), .BUS_WIDTH(32), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(valid3), .req_ready(ready3), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rv3), .resp_rdata(rd3), .resp_error(re3), .bus(b3)
  );

  // ---------------- secondaries: byte memories with alignment/range faults ----------------
  logic [7:0] mem1 [MEM_BYTES];
  logic [7:0] mem3 [MEM_BYTES];

  function automatic logic sec_err(input logic [31:0] a, input logic [1:0] s);
    return (a >= MEM_BYTES) || (s == 2'b11) || (s == 2'b01 && a[0]) ||
           (s == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic logic lane_en(input logic [1:0] a, input logic [1:0] s, input int i);
    logic [1:0] li;
    li = 2'(i);
    if (s == 2'b00) return li == a;
    if (s == 2'b01) return li[1] == a[1];
    return 1'b1;
  endfunction

  assign b1.error = sec_err(b1.addr, b1.size);
  assign b3.error = sec_err(b3.addr, b3.size);
  assign b1.rdata = {mem1[{b1.addr[9:2], 2'd3}], mem1[{b1.addr[9:2], 2'd2}],
                     mem1[{b1.addr[9:2], 2'd1}], mem1[{b1.addr[9:2], 2'd0}]};
  assign b3.rdata = {mem3[{b3.addr[9:2], 2'd3}], mem3[{b3.addr[9:2], 2'd2}],
                     mem3[{b3.addr[9:2], 2'd1}], mem3[{b3.addr[9:2], 2'd0}]};

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int j = 0; j < MEM_BYTES; j++) mem1[j] <= 8'h00;
    end else if (b1.wr && !b1.error) begin
      for (int i = 0; i < 4; i++)
        if (lane_en(b1.addr[1:0], b1.size, i)) mem1[{b1.addr[9:2], 2'(i)}] <= b1.wdata[8*i +: 8];
    end
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int j = 0; j < MEM_BYTES; j++) mem3[j] <= 8'h00;
    end else if (b3.wr && !b3.error) begin
      for (int i = 0; i < 4; i++)
        if (lane_en(b3.addr[1:0], b3.size, i)) mem3[{b3.addr[9:2], 2'(i)}] <= b3.wdata[8*i +: 8];
    end
  end

  // ---------------- reference model: little-endian byte memory ----------------
  logic [7:0] ref_mem [MEM_BYTES];

  function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic err, output logic [31:0] rdata);
    int nb;
    logic [31:0] v;
    rdata = 32'h0;
    err   = 1'b0;
    if (size == 2'b11) begin
      err = 1'b1;
      return;
    end
    nb = 1 << size;
    if ((addr % nb) != 0 || addr >= MEM_BYTES) begin
      err = 1'b1;
      return;
    end
    if (we) begin
      for (int i = 0; i < nb; i++) ref_mem[addr[9:0] + 10'(i)] = wdata[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[addr[9:0] + 10'(i)];
      if (!uns && nb < 4 && v[8*nb-1])
        for (int j = 8*nb; j < 32; j++) v[j] = 1'b1;
      rdata = v;
    end
  endfunction

  function automatic logic [31:0] lanes(input logic [1:0] size, input logic [31:0] d);
    if (size == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (size == 2'b01) return {d[15:0], d[15:0]};
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request to both units in lockstep; req_valid stays high until each
  // unit's response pulse, so any second accept would be counted.
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    logic        exp_err, exp_strobe;
    logic [31:0] exp_rd;
    int          exp_c1, exp_c3;
    int          rc1, rc3, rn1, rn3, sn1, sn3, sc1, sc3, acc1, acc3;
    logic        sw1, sw3, ge1, ge3;
    logic [31:0] sa1, sa3, swd1, swd3, g1, g3;
    logic [1:0]  ss1, ss3;
    model(we, size, uns, addr, wdata, exp_err, exp_rd);
    exp_strobe = (size != 2'b11);
    exp_c1 = exp_strobe ? 3 : 1;
    exp_c3 = exp_strobe ? 5 : 1;
    rc1 = 0; rc3 = 0; rn1 = 0; rn3 = 0; sn1 = 0; sn3 = 0; sc1 = 0; sc3 = 0;
    sw1 = 1'bx; sw3 = 1'bx; sa1 = 'x; sa3 = 'x; swd1 = 'x; swd3 = 'x; ss1 = 'x; ss3 = 'x;
    g1 = 'x; g3 = 'x; ge1 = 1'bx; ge3 = 1'bx;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    valid1 = 1'b1; valid3 = 1'b1;
    chk({tag, ":rdy1"}, 32'(ready1), 32'd1);
    chk({tag, ":rdy3"}, 32'(ready3), 32'd1);
    acc1 = int'(ready1); acc3 = int'(ready3);
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (valid1 && ready1) acc1++;
      if (valid3 && ready3) acc3++;
      if (b1.rd || b1.wr) begin
        sn1++; sc1 = k; sw1 = b1.wr; sa1 = b1.addr; ss1 = b1.size; swd1 = b1.wdata;
      end
      if (b3.rd || b3.wr) begin
        sn3++; sc3 = k; sw3 = b3.wr; sa3 = b3.addr; ss3 = b3.size; swd3 = b3.wdata;
      end
      if (rv1) begin rn1++; rc1 = k; g1 = rd1; ge1 = re1; valid1 = 1'b0; end
      if (rv3) begin rn3++; rc3 = k; g3 = rd3; ge3 = re3; valid3 = 1'b0; end
    end
    valid1 = 1'b0; valid3 = 1'b0;
    chk({tag, ":nresp1"}, 32'(rn1), 32'd1);
    chk({tag, ":nresp3"}, 32'(rn3), 32'd1);
    chk({tag, ":cyc1"}, 32'(rc1), 32'(exp_c1));
    chk({tag, ":cyc3"}, 32'(rc3), 32'(exp_c3));
    chk({tag, ":rdata1"}, g1, exp_rd);
    chk({tag, ":rdata3"}, g3, exp_rd);
    chk({tag, ":err1"}, 32'(ge1), 32'(exp_err));
    chk({tag, ":err3"}, 32'(ge3), 32'(exp_err));
    chk({tag, ":nstrobe1"}, 32'(sn1), 32'(exp_strobe));
    chk({tag, ":nstrobe3"}, 32'(sn3), 32'(exp_strobe));
    chk({tag, ":acc1"}, 32'(acc1), 32'd1);
    chk({tag, ":acc3"}, 32'(acc3), 32'd1);
    chk({tag, ":idle1"}, 32'(ready1), 32'd1);
    chk({tag, ":idle3"}, 32'(ready3), 32'd1);
    if (exp_strobe) begin
      chk({tag, ":scyc1"}, 32'(sc1), 32'd1);
      chk({tag, ":scyc3"}, 32'(sc3), 32'd1);
      chk({tag, ":swr1"}, 32'(sw1), 32'(we));
      chk({tag, ":swr3"}, 32'(sw3), 32'(we));
      chk({tag, ":saddr1"}, sa1, addr);
      chk({tag, ":saddr3"}, sa3, addr);
      chk({tag, ":ssize1"}, 32'(ss1), 32'(size));
      chk({tag, ":ssize3"}, 32'(ss3), 32'(size));
      chk({tag, ":hold_addr1"}, b1.addr, addr);
      if (we) begin
        chk({tag, ":swdata1"}, swd1, lanes(size, wdata));
        chk({tag, ":swdata3"}, swd3, lanes(size, wdata));
      end
    end
    last_rd1 = g1; last_err1 = ge1; last_rc1 = rc1; last_sn1 = sn1; last_swd1 = swd1;
  endtask

  initial begin
    int          quiet;
    logic        r_we, r_uns;
    logic [1:0]  r_size;
    logic [31:0] r_addr;

    for (int j = 0; j < MEM_BYTES; j++) ref_mem[j] = 8'h00;
    rst = 1'b1; mem_clr = 1'b1;
    valid1 = 1'b0; valid3 = 1'b0;
    req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst:resp_valid1", 32'(rv1), 32'd0);
    chk("rst:resp_rdata1", rd1, 32'd0);
    chk("rst:resp_error1", 32'(re1), 32'd0);
    chk("rst:rdwr1", {30'd0, b1.rd, b1.wr}, 32'd0);
    chk("rst:rdwr3", {30'd0, b3.rd, b3.wr}, 32'd0);
    chk("rst:addr1", b1.addr, 32'd0);
    chk("rst:size1", 32'(b1.size), 32'd0);
    chk("rst:wdata1", b1.wdata, 32'd0);
    chk("rst:resp_valid3", 32'(rv3), 32'd0);
    mem_clr = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst:ready1", 32'(ready1), 32'd1);
    chk("rst:ready3", 32'(ready3), 32'd1);

    // Directed cases.
    run_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, "t1_sw");
    run_req(1'b1, 2'b00, 1'b0, 32'h103, 32'h000000A5, "t2_sb");
    chk("t2:wdata_lanes", last_swd1, 32'hA5A5A5A5);
    run_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, "t2_lb");
    chk("t2:lb_signed", last_rd1, 32'hFFFFFFA5);
    run_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, "t2_lbu");
    chk("t2:lb_unsigned", last_rd1, 32'h000000A5);
    run_req(1'b1, 2'b10, 1'b0, 32'h100, 32'h80011234, "t3_sw");
    run_req(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, "t3_lh");
    chk("t3:lh_signed", last_rd1, 32'hFFFF8001);
    run_req(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, "t3_lhu");
    chk("t3:lh_unsigned", last_rd1, 32'h00008001);
    run_req(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, "t4_misal");
    chk("t4:misal_err", 32'(last_err1), 32'd1);
    chk("t4:misal_rdata", last_rd1, 32'd0);
    run_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, "t4_ill");
    chk("t4:ill_cycle", 32'(last_rc1), 32'd1);
    chk("t4:ill_nostrobe", 32'(last_sn1), 32'd0);

    // Random traffic concentrated on a small window so loads hit earlier stores.
    for (int i = 0; i < 40; i++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_uns  = 1'($urandom_range(0, 1));
      r_size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      r_addr = ($urandom_range(0, 7) == 0) ? 32'(MEM_BYTES - 4 + $urandom_range(0, 7))
                                           : 32'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0 && r_size != 2'b11)
        r_addr = r_addr & ~((32'd1 << r_size) - 32'd1);
      run_req(r_we, r_size, r_uns, r_addr, $urandom, $sformatf("rnd%0d", i));
    end

    // Reset while DUT3 is waiting and DUT1 is pulsing its response.
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h100;
    valid1 = 1'b1; valid3 = 1'b1;
    @(posedge clk);
    #1;
    valid1 = 1'b0; valid3 = 1'b0;
    @(negedge clk);
    chk("t6:strobe3", 32'(b3.rd), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("t6:resp1_before", 32'(rv1), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6:resp_valid1", 32'(rv1), 32'd0);
    chk("t6:resp_valid3", 32'(rv3), 32'd0);
    chk("t6:rdwr3", {30'd0, b3.rd, b3.wr}, 32'd0);
    chk("t6:addr3", b3.addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rv1 || rv3 || b1.rd || b1.wr || b3.rd || b3.wr) quiet++;
    end
    chk("t6:no_activity", 32'(quiet), 32'd0);
    run_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, "t6_after");
    chk("t6:after_rdata", last_rd1, 32'h80011234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
